// File: rtl/tsb_bus_arbiter_if.sv
// Request/enable bundle between requesters, the tri-state arbiter and the TSB bank.
interface tsb_bus_arbiter_if #(
    parameter int unsigned N = 4
);
    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  en;
    logic [GW-1:0] grant_id;
    logic          busy;
    logic          preempt;

    modport master (
        output req,
        input  en,
        input  grant_id,
        input  busy,
        input  preempt
    );

    modport slave (
        input  req,
        output en,
        output grant_id,
        output busy,
        output preempt
    );
endinterface

// File: rtl/tsb_bus_arbiter.sv
// Round-robin owner arbiter for a shared tri-state net with an all-off turnaround gap.
// Optional hold timeout with forced release is compiled in with TSB_ARB_TIMEOUT_EN.
module tsb_bus_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned TURN     = 1,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic clk,
    input  logic rst,
    tsb_bus_arbiter_if.slave bus
);
    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned TW = $clog2(TURN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_TURN  = 2'd2
    } state_t;

    state_t        state;
    logic [GW-1:0] last;
    logic [TW-1:0] turn_cnt;

    logic          arb_found;
    logic [GW-1:0] arb_win;
    logic [GW-1:0] idx;

`ifdef TSB_ARB_TIMEOUT_EN
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt;
`else
    assign bus.preempt = 1'b0;
`endif

    // First set request at or after last+1, wrapping around.
    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        idx       = '0;
        for (int i = 1; i <= int'(N); i++) begin
            idx = GW'((int'(last) + i) % int'(N));
            if (!arb_found && bus.req[idx]) begin
                arb_found = 1'b1;
                arb_win   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            last         <= GW'(N - 1);
            turn_cnt     <= '0;
            bus.en       <= '0;
            bus.grant_id <= '0;
            bus.busy     <= 1'b0;
`ifdef TSB_ARB_TIMEOUT_EN
            hold_cnt     <= '0;
            bus.preempt  <= 1'b0;
`endif
        end else begin
`ifdef TSB_ARB_TIMEOUT_EN
            bus.preempt <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (arb_found) begin
                        bus.en       <= N'(1) << arb_win;
                        bus.grant_id <= arb_win;
                        bus.busy     <= 1'b1;
                        last         <= arb_win;
                        state        <= S_GRANT;
`ifdef TSB_ARB_TIMEOUT_EN
                        hold_cnt     <= '0;
`endif
                    end
                end

                S_GRANT: begin
                    if (!bus.req[bus.grant_id]) begin
                        bus.en   <= '0;
                        bus.busy <= 1'b0;
                        turn_cnt <= TW'(TURN);
                        state    <= S_TURN;
`ifdef TSB_ARB_TIMEOUT_EN
                    // A release on the timeout cycle is handled above as a normal release.
                    end else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                        bus.en      <= '0;
                        bus.busy    <= 1'b0;
                        bus.preempt <= 1'b1;
                        turn_cnt    <= TW'(TURN);
                        state       <= S_TURN;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
`endif
                    end
                end

                S_TURN: begin
                    // Last gap cycle: hand straight to the next owner if anyone is waiting.
                    if (turn_cnt <= TW'(1)) begin
                        turn_cnt <= '0;
                        if (arb_found) begin
                            bus.en       <= N'(1) << arb_win;
                            bus.grant_id <= arb_win;
                            bus.busy     <= 1'b1;
                            last         <= arb_win;
                            state        <= S_GRANT;
`ifdef TSB_ARB_TIMEOUT_EN
                            hold_cnt     <= '0;
`endif
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        turn_cnt <= turn_cnt - TW'(1);
                    end
                end

                default: begin
                    bus.en   <= '0;
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tsb_bus_arbiter.sv
// Directed vector bench for tsb_bus_arbiter (N=4, TURN=1, MAX_HOLD=4), either timeout build.
module tb_tsb_bus_arbiter;
    localparam int unsigned N = 4;

`ifdef TSB_ARB_TIMEOUT_EN
    localparam bit TO = 1'b1;
`else
    localparam bit TO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    tsb_bus_arbiter_if #(.N(N)) bus ();

    tsb_bus_arbiter #(
        .N(N),
        .TURN(1),
        .MAX_HOLD(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Inputs applied before an edge, outputs required right after it.
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] en;
        logic [1:0] gid;
        logic       pre;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] e,
                       input logic [1:0] g, input logic p, input string nm);
        vec_t v;
        v.rst = r; v.req = q; v.en = e; v.gid = g; v.pre = p; v.name = nm;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] prev_en;
        logic       exp_busy;
        logic       chk_gid;
        bit         ok;

        rst     = 1'b1;
        bus.req = '0;
        prev_en = '0;

        // Reset and quiet idle
        add(1, 4'b0000, 4'b0000, 0, 0, "s1 reset");
        for (int i = 0; i < 5; i++) add(0, 4'b0000, 4'b0000, 0, 0, "s1 idle");

        // Two simultaneous requests, handoff through one gap cycle
        add(0, 4'b0101, 4'b0001, 0, 0, "s2 grant0");
        add(0, 4'b0101, 4'b0001, 0, 0, "s2 hold0");
        add(0, 4'b0100, 4'b0000, 0, 0, "s2 release0");
        add(0, 4'b0100, 4'b0100, 2, 0, "s2 grant2");
        add(0, 4'b0000, 4'b0000, 0, 0, "s2 release2");
        add(0, 4'b0000, 4'b0000, 0, 0, "s2 idle");

        // Full rotation with all requesting
        add(1, 4'b0000, 4'b0000, 0, 0, "s3 reset");
        add(0, 4'b1111, 4'b0001, 0, 0, "s3 grant0");
        add(0, 4'b1111, 4'b0001, 0, 0, "s3 hold0");
        add(0, 4'b1110, 4'b0000, 0, 0, "s3 gap0");
        add(0, 4'b1111, 4'b0010, 1, 0, "s3 grant1");
        add(0, 4'b1111, 4'b0010, 1, 0, "s3 hold1");
        add(0, 4'b1101, 4'b0000, 0, 0, "s3 gap1");
        add(0, 4'b1111, 4'b0100, 2, 0, "s3 grant2");
        add(0, 4'b1111, 4'b0100, 2, 0, "s3 hold2");
        add(0, 4'b1011, 4'b0000, 0, 0, "s3 gap2");
        add(0, 4'b1111, 4'b1000, 3, 0, "s3 grant3");
        add(0, 4'b1111, 4'b1000, 3, 0, "s3 hold3");
        add(0, 4'b0111, 4'b0000, 0, 0, "s3 gap3");
        add(0, 4'b1111, 4'b0001, 0, 0, "s3 regrant0");
        add(0, 4'b0000, 4'b0000, 0, 0, "s3 release");
        add(0, 4'b0000, 4'b0000, 0, 0, "s3 idle");

        // Hold timeout (or unlimited hold without the timeout build)
        add(1, 4'b0000, 4'b0000, 0, 0, "s4 reset");
        add(0, 4'b0011, 4'b0001, 0, 0, "s4 grant0");
        add(0, 4'b0011, 4'b0001, 0, 0, "s4 hold1");
        add(0, 4'b0011, 4'b0001, 0, 0, "s4 hold2");
        add(0, 4'b0011, 4'b0001, 0, 0, "s4 hold3");
        add(0, 4'b0011, TO ? 4'b0000 : 4'b0001, 0, TO, "s4 timeout");
        add(0, 4'b0011, TO ? 4'b0010 : 4'b0001, TO ? 2'd1 : 2'd0, 0, "s4 after");
        add(0, 4'b0000, 4'b0000, 0, 0, "s4 release");
        add(0, 4'b0000, 4'b0000, 0, 0, "s4 idle");

        // Release on the exact timeout cycle is a plain release
        add(1, 4'b0000, 4'b0000, 0, 0, "s4b reset");
        add(0, 4'b0001, 4'b0001, 0, 0, "s4b grant0");
        add(0, 4'b0001, 4'b0001, 0, 0, "s4b hold1");
        add(0, 4'b0001, 4'b0001, 0, 0, "s4b hold2");
        add(0, 4'b0001, 4'b0001, 0, 0, "s4b hold3");
        add(0, 4'b0000, 4'b0000, 0, 0, "s4b release");
        add(0, 4'b0000, 4'b0000, 0, 0, "s4b idle");

        // Reset mid-grant, then immediate regrant
        add(1, 4'b0000, 4'b0000, 0, 0, "s5 reset");
        add(0, 4'b0100, 4'b0100, 2, 0, "s5 grant2");
        add(0, 4'b0100, 4'b0100, 2, 0, "s5 hold2");
        add(1, 4'b0100, 4'b0000, 0, 0, "s5 rst mid");
        add(0, 4'b0100, 4'b0100, 2, 0, "s5 regrant2");
        add(0, 4'b0000, 4'b0000, 0, 0, "s5 release");
        add(0, 4'b0000, 4'b0000, 0, 0, "s5 idle");

        // Request living only inside the gap is never granted
        add(1, 4'b0000, 4'b0000, 0, 0, "s6 reset");
        add(0, 4'b0001, 4'b0001, 0, 0, "s6 grant0");
        add(0, 4'b0010, 4'b0000, 0, 0, "s6 release");
        add(0, 4'b0000, 4'b0000, 0, 0, "s6 gap end");
        add(0, 4'b0000, 4'b0000, 0, 0, "s6 idle");

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst     = vecs[i].rst;
            bus.req = vecs[i].req;
            @(posedge clk);
            #1;
            n_vec++;
            exp_busy = |vecs[i].en;
            chk_gid  = vecs[i].rst || exp_busy;
            ok = (bus.en === vecs[i].en) && (bus.busy === exp_busy) &&
                 (bus.preempt === vecs[i].pre) &&
                 (!chk_gid || (bus.grant_id === vecs[i].gid));
            if (!ok) begin
                n_miss++;
                $display("FAIL vec %0d %s: got en=%b busy=%b grant_id=%0d preempt=%b, want en=%b busy=%b grant_id=%0d preempt=%b",
                         i, vecs[i].name, bus.en, bus.busy, bus.grant_id, bus.preempt,
                         vecs[i].en, exp_busy, vecs[i].gid, vecs[i].pre);
            end
            // Line-safety invariants on every cycle
            if ($countones(bus.en) > 1 ||
                (bus.en != 4'b0000 && prev_en != 4'b0000 && bus.en != prev_en)) begin
                n_miss++;
                $display("FAIL vec %0d %s invariant: en=%b prev en=%b", i, vecs[i].name, bus.en, prev_en);
            end
            prev_en = bus.en;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/tsb_bus_arbiter.md
# tsb_bus_arbiter

Round-robin arbiter and enable sequencer for a shared tri-state line driven by several `TSB` tri-state buffers. The block owns the `en` inputs of up to N buffers that share one output net. It guarantees at most one driver is enabled at any time, and it inserts an all-off turnaround gap between owners so that no two buffers fight during their rise and fall delays. It sits between the requesting logic and the bank of `TSB` instances.

## Interface
Parameters:
- `N`, 4: number of requesters / `TSB` instances (2..16).
- `TURN`, 1: turnaround cycles with all enables low between two grants (≥1).
- `MAX_HOLD`, 16: maximum consecutive cycles one owner may hold the line (≥1). Used only with the timeout feature.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in N: request vector. Bit i high means requester i wants to drive the line. The requester holds it high for as long as it needs the line.
- `en` out N: registered enables to `TSB[i].en`. Always one-hot or zero.
- `grant_id` out clog2(N): index of the current owner. Valid while `busy`=1.
- `busy` out 1: high while some `en` bit is high.
- `preempt` out 1: one-cycle pulse when an owner is force-released by timeout.

## Operation
- States:
  - IDLE: `en`=0.
  - GRANT: exactly one `en` bit high.
  - TURN: `en`=0, counting down the gap.
- Reset values:
  - All outputs: `en`=0, `grant_id`=0, `busy`=0, `preempt`=0.
  - Internal: state IDLE, round-robin pointer `last`=N-1, all counters 0.
- Arbitration function:
  - Search for the first set `req` bit, starting at index (`last`+1) mod N and wrapping.
  - The winner w gets `en`=1<<w and `grant_id`=w, and `last` becomes w.
  - After reset, bit 0 therefore has the highest priority.
- IDLE: if `req`≠0, arbitrate and go to GRANT. Otherwise stay in IDLE.
- GRANT:
  - If `req[grant_id]`=0, drop `en`, load the turn counter with TURN, and go to TURN.
  - The hold counter increments every cycle spent in GRANT.
- TURN:
  - Decrement the turn counter each cycle.
  - When it reaches the last cycle: if `req`≠0, arbitrate and go directly to GRANT; otherwise go to IDLE.
- Requests from non-owners are ignored while in GRANT. They never disturb the current owner.
- Requests that appear and disappear entirely within a TURN window are never granted.
- Reset asserted in any state, including mid-GRANT, forces all reset values on the next edge. `en` is 0 from that edge onward.

## Timing
- Request to enable: `req` sampled at edge k in IDLE gives `en` high after edge k. That is 1-cycle latency.
- Release: owner's `req` sampled low at edge m gives `en`=0 after edge m.
- Turnaround: after a release, the next `en` rises after edge m+TURN. There are exactly TURN all-zero cycles between owners, including when the same requester is regranted.
- No cycle ever has more than one `en` bit high. There is no combinational path from `req` to `en`.
- `busy` equals the OR of `en`, and is registered in the same cycle as `en`.
- `preempt` is high for the single cycle immediately after the forced drop of `en`.

## Configuration
- Macro `TSB_ARB_TIMEOUT_EN`.
- Defined:
  - In GRANT, if the owner has held the line for MAX_HOLD cycles with `req` still high, drop `en`, pulse `preempt`, and enter TURN.
  - Arbitration then starts at `last`+1, so any other pending requester wins. If no one else requests, the same owner is regranted after the TURN gap.
  - If the owner's release coincides with the timeout, it is treated as a normal release and `preempt` stays 0.
- Undefined:
  - There is no hold counter and no timeout logic. `preempt` is tied to 0.
  - An owner keeps the line until it drops `req`.

## Test plan
All scenarios use N=4, TURN=1, MAX_HOLD=4.

1. Reset then `req`=4'b0000 for 5 cycles -> `en`=0, `busy`=0, `grant_id`=0, `preempt`=0 throughout.
2. `req`=4'b0101 asserted together from IDLE -> `en`=0001 one cycle later. Drop `req[0]` -> 1 cycle of `en`=0000, then `en`=0100 with `grant_id`=2.
3. `req`=4'b1111 held constant, owners release after 2 cycles each -> grant order 0,1,2,3,0. Each grant is separated by exactly one all-zero `en` cycle.
4. With `TSB_ARB_TIMEOUT_EN`, `req`=4'b0011 held high -> `en`=0001 for exactly 4 cycles, then `preempt` pulses with `en`=0000 for 1 cycle, then `en`=0010. Without the macro, `en`=0001 persists and `preempt` stays 0.
5. `rst` pulsed for 1 cycle while `en`=0100 -> `en`=0000 after that edge. With `req` still 4'b0100, the next grant is `en`=0100 one cycle after `rst` deasserts.
6. Monitor runs across all scenarios -> `en` never has more than one bit set, and no owner change occurs without at least one `en`=0 cycle.
